// File: rtl/swo_pkg.sv
// Shared types and constants for the SWO/NRZ bench transmitter.
package swo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } swo_state_e;

  // Console characters the capture gadget gives special meaning to
  localparam logic [7:0] SWO_CHAR_CR  = 8'h0D;
  localparam logic [7:0] SWO_CHAR_LF  = 8'h0A;
  localparam logic [7:0] SWO_CHAR_EOT = 8'h04;

  // Start bit plus eight data bits; stop bits are counted separately
  localparam int SWO_FRAME_BITS = 9;

endpackage

// File: rtl/swo_tx_fifo.sv
// Byte FIFO feeding the frame serialiser. Pointers carry one extra MSB so
// full and empty can be told apart without a separate counter.
module swo_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  // Read is from storage only: a byte written on an edge is visible after it
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because pointers gate visibility
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update, wrapping naturally through the extra MSB
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/swo_uart_tx.sv
// Bench-side SWO transmitter: queues bytes and serialises them as 8N1-style
// NRZ frames at one bit per CLK, LSB first, with optional extra stop bits
// and idle gap between frames.
module swo_uart_tx
  import swo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int IDLE_GAP   = 0
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          ENABLE,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [7:0]                    IN_DATA,
  output logic                          SWO,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [15:0]                   FRAMES_SENT
);

  localparam logic [2:0]  DATA_LAST = 3'(SWO_FRAME_BITS - 2);
  localparam logic [15:0] STOP_LAST = 16'(STOP_BITS - 1);
  localparam logic [15:0] GAP_LAST  = 16'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  swo_state_e  state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] cnt;
  logic        swo_q;
  logic [15:0] frames;

  logic        push, pop, full, empty, can_start, stop_last, gap_last, decide;
  logic [7:0]  head;

  assign push      = IN_VALID & IN_READY;
  assign can_start = ENABLE & ~empty;
  assign stop_last = (state == STOP) && (cnt == STOP_LAST);
  assign gap_last  = (state == GAP) && (cnt == GAP_LAST);
  // Points where a new frame may be launched straight from the FIFO head
  assign decide    = (state == IDLE) || (stop_last && (IDLE_GAP == 0)) || gap_last;
  assign pop       = decide & can_start;

  swo_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (push),
    .pop    (pop),
    .din    (IN_DATA),
    .dout   (head),
    .level  (FIFO_LEVEL),
    .full   (full),
    .empty  (empty)
  );

  assign IN_READY    = ~full;
  assign SWO         = swo_q;
  assign BUSY        = (state != IDLE) || ~empty;
  assign FRAMES_SENT = frames;

  // Frame FSM: every SWO level is registered here, so the line never glitches
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
      swo_q   <= 1'b1;
      frames  <= '0;
    end else begin
      case (state)
        IDLE: begin
          swo_q <= 1'b1;
          if (pop) begin
            shift <= head;
            swo_q <= 1'b0;
            state <= START;
          end
        end
        START: begin
          swo_q   <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            swo_q <= 1'b1;
            cnt   <= '0;
            state <= STOP;
          end else begin
            swo_q   <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_last) begin
            frames <= frames + 1'b1;
            cnt    <= '0;
            if (IDLE_GAP > 0) begin
              swo_q <= 1'b1;
              state <= GAP;
            end else if (pop) begin
              shift <= head;
              swo_q <= 1'b0;
              state <= START;
            end else begin
              swo_q <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_last) begin
            cnt <= '0;
            if (pop) begin
              shift <= head;
              swo_q <= 1'b0;
              state <= START;
            end else begin
              swo_q <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          swo_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swo_uart_tx.sv
// Directed bench for swo_uart_tx: one instance at default parameters and one
// with two stop bits and a three-cycle idle gap.
module tb_swo_uart_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en0, v0, rdy0, swo0, busy0;
  logic [7:0]  d0;
  logic [3:0]  lvl0;
  logic [15:0] frm0;
  logic        en1, v1, rdy1, swo1, busy1;
  logic [7:0]  d1;
  logic [3:0]  lvl1;
  logic [15:0] frm1;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl [9] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};

  always #5 clk = ~clk;

  swo_uart_tx dut0 (
    .CLK(clk), .RESETn(rstn), .ENABLE(en0), .IN_VALID(v0), .IN_READY(rdy0),
    .IN_DATA(d0), .SWO(swo0), .BUSY(busy0), .FIFO_LEVEL(lvl0), .FRAMES_SENT(frm0)
  );

  swo_uart_tx #(.FIFO_DEPTH(8), .STOP_BITS(2), .IDLE_GAP(3)) dut1 (
    .CLK(clk), .RESETn(rstn), .ENABLE(en1), .IN_VALID(v1), .IN_READY(rdy1),
    .IN_DATA(d1), .SWO(swo1), .BUSY(busy1), .FIFO_LEVEL(lvl1), .FRAMES_SENT(frm1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check nbits line cycles of one frame; optionally drop ENABLE after bit drop_at
  task automatic frame(input bit sel, input logic [7:0] b, input int nbits,
                       input int drop_at, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      tick();
      chk($sformatf("%s bit%0d", tag, i), sel ? swo1 : swo0, (i < 10) ? f[i] : 1'b1);
      if (i == drop_at) begin
        if (sel) en1 = 1'b0;
        else     en0 = 1'b0;
      end
    end
  endtask

  initial begin
    rstn = 1'b0; en0 = 1'b0; v0 = 1'b0; d0 = '0; en1 = 1'b0; v1 = 1'b0; d1 = '0;
    tick(); tick();
    chk("rst swo", swo0, 1); chk("rst ready", rdy0, 1); chk("rst busy", busy0, 0);
    chk("rst level", lvl0, 0); chk("rst frames", frm0, 0);
    rstn = 1'b1;
    tick();

    // Single byte straight into an idle, enabled block
    en0 = 1'b1; v0 = 1'b1; d0 = 8'h41;
    tick();
    v0 = 1'b0;
    chk("single level", lvl0, 1); chk("single idle swo", swo0, 1);
    frame(0, 8'h41, 10, -1, "single");
    chk("single busy in stop", busy0, 1);
    tick();
    chk("single frames", frm0, 1); chk("single busy end", busy0, 0); chk("single idle", swo0, 1);

    // Back-to-back frames from a preloaded FIFO
    en0 = 1'b0; v0 = 1'b1;
    d0 = 8'h48; tick(); d0 = 8'h69; tick(); d0 = 8'h0A; tick();
    v0 = 1'b0;
    chk("b2b level", lvl0, 3); chk("b2b held swo", swo0, 1);
    en0 = 1'b1;
    frame(0, 8'h48, 10, -1, "b2b0");
    frame(0, 8'h69, 10, -1, "b2b1");
    frame(0, 8'h0A, 10, -1, "b2b2");
    tick();
    chk("b2b frames", frm0, 4); chk("b2b busy", busy0, 0);

    // FIFO full with IN_VALID held high
    en0 = 1'b0; v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = tbl[i];
      tick();
    end
    chk("full level", lvl0, 8); chk("full ready", rdy0, 0);
    d0 = tbl[8];
    tick();
    chk("full level hold", lvl0, 8); chk("full swo", swo0, 1);
    en0 = 1'b1;
    tick();
    chk("full pop level", lvl0, 7); chk("full pop ready", rdy0, 1); chk("full start", swo0, 0);
    tick();
    v0 = 1'b0;
    chk("full refill level", lvl0, 8); chk("full b0 bit1", swo0, tbl[0][0]);
    for (int i = 2; i < 10; i++) begin
      logic [9:0] f;
      f = {1'b1, tbl[0], 1'b0};
      tick();
      chk($sformatf("full b0 bit%0d", i), swo0, f[i]);
    end
    for (int k = 1; k < 9; k++) frame(0, tbl[k], 10, -1, $sformatf("full b%0d", k));
    tick();
    chk("full frames", frm0, 13); chk("full busy", busy0, 0); chk("full empty", lvl0, 0);

    // Two stop bits plus idle gap: start bits 14 cycles apart
    v1 = 1'b1;
    d1 = 8'h55; tick(); d1 = 8'hAA; tick();
    v1 = 1'b0;
    en1 = 1'b1;
    frame(1, 8'h55, 14, -1, "gap55");
    frame(1, 8'hAA, 14, -1, "gapAA");
    tick();
    chk("gap frames", frm1, 2); chk("gap busy", busy1, 0); chk("gap idle", swo1, 1);

    // ENABLE dropped mid-DATA: frame completes, next one is held
    en1 = 1'b0; v1 = 1'b1;
    d1 = 8'h0F; tick(); d1 = 8'hF0; tick();
    v1 = 1'b0;
    en1 = 1'b1;
    frame(1, 8'h0F, 14, 3, "gate0F");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gate hold%0d", i), swo1, 1);
    end
    chk("gate level", lvl1, 1); chk("gate frames", frm1, 3); chk("gate busy", busy1, 1);
    en1 = 1'b1;
    frame(1, 8'hF0, 14, -1, "gateF0");
    tick();
    chk("gate frames end", frm1, 4);

    // Reset in the middle of a frame with more bytes queued
    en0 = 1'b0; v0 = 1'b1;
    d0 = 8'hC3; tick(); d0 = 8'h11; tick(); d0 = 8'h22; tick();
    v0 = 1'b0;
    en0 = 1'b1;
    frame(0, 8'hC3, 4, -1, "rstC3");
    chk("rst pre swo low", swo0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst swo", swo0, 1); chk("midrst level", lvl0, 0);
    chk("midrst frames", frm0, 0); chk("midrst busy", busy0, 0);
    #1 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("postrst swo%0d", i), swo0, 1);
    end
    chk("postrst frames", frm0, 0); chk("postrst busy", busy0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
